fpu_op_sequencer: RTL

Upstream issue stage for the FPU `ALU` (add/mul). It accepts tagged operation commands through a valid/ready port and buffers them in a DEPTH-entry FIFO. It issues one command at a time to the ALU as a single-cycle `i_vld` pulse, then waits for the ALU's `o_res_vld`. It returns each result in order with its tag over a valid/ready port, and substitutes a quiet NaN if the ALU does not answer within TIMEOUT cycles.

---
 rtl/fpu_op_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
//   Issue stage in front of the FPU add/mul ALU. Commands are buffered in a
//   DEPTH-entry FIFO, issued one at a time as a single-cycle o_alu_vld pulse,
//   and each ALU answer is returned in order with its tag. If the ALU stays
//   silent for TIMEOUT cycles, a quiet NaN is returned with o_res_timeout set.
//
//   State | meaning
//   IDLE  | no operation outstanding; issue the FIFO head when one is present
//   WAIT  | operation issued, waiting for the ALU result or the timeout
//   HOLD  | result presented on the result port until i_res_rdy
//
// Ports
//   clk, rst                          clock, async active-high reset
//   i_cmd_vld/o_cmd_rdy               command handshake
//   i_cmd_a/b/op/tag                  command operands, opcode (1 = mul), tag
//   o_alu_a/b/op, o_alu_vld           issue port to the ALU
//   i_alu_res/_res_vld/_ovf           ALU answer
//   o_res_vld/i_res_rdy               result handshake
//   o_res/_ovf/_tag/_timeout          result payload

module fpu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_vld,
    output logic             o_cmd_rdy,
    input  logic [31:0]      i_cmd_a,
    input  logic [31:0]      i_cmd_b,
    input  logic             i_cmd_op,
    input  logic [TAG_W-1:0] i_cmd_tag,
    output logic [31:0]      o_alu_a,
    output logic [31:0]      o_alu_b,
    output logic             o_alu_op,
    output logic             o_alu_vld,
    input  logic [31:0]      i_alu_res,
    input  logic             i_alu_res_vld,
    input  logic             i_alu_ovf,
    output logic             o_res_vld,
    input  logic             i_res_rdy,
    output logic [31:0]      o_res,
    output logic             o_res_ovf,
    output logic [TAG_W-1:0] o_res_tag,
    output logic             o_res_timeout
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WCNT_W = $clog2(TIMEOUT);
    localparam int ENT_W  = 65 + TAG_W;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [WCNT_W-1:0]  wcnt_q;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [TAG_W-1:0]   pend_tag_q;

    logic [31:0]        alu_a_q, alu_b_q, res_q;
    logic               alu_op_q, alu_vld_q, res_vld_q, res_ovf_q, res_tmo_q;
    logic [TAG_W-1:0]   res_tag_q;

    logic               push, pop;
    logic [31:0]        head_a, head_b;
    logic               head_op;
    logic [TAG_W-1:0]   head_tag;

    assign o_cmd_rdy = (count_q < CNT_W'(DEPTH));
    assign push      = i_cmd_vld && o_cmd_rdy;
    // The pop is the issue transition itself.
    assign pop       = (state_q == IDLE) && (count_q != '0);

    assign {head_a, head_b, head_op, head_tag} = mem_q[rd_ptr_q];

    // Storage needs no reset: only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_cmd_a, i_cmd_b, i_cmd_op, i_cmd_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wcnt_q     <= '0;
            pend_tag_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= 1'b0;
            alu_vld_q  <= 1'b0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_tmo_q  <= 1'b0;
            res_tag_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        alu_a_q    <= head_a;
                        alu_b_q    <= head_b;
                        alu_op_q   <= head_op;
                        pend_tag_q <= head_tag;
                        alu_vld_q  <= 1'b1;
                        wcnt_q     <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    alu_vld_q <= 1'b0;
                    wcnt_q    <= wcnt_q + WCNT_W'(1);
                    // A real answer wins over a timeout in the same cycle.
                    if (i_alu_res_vld) begin
                        res_q     <= i_alu_res;
                        res_ovf_q <= i_alu_ovf;
                        res_tag_q <= pend_tag_q;
                        res_tmo_q <= 1'b0;
                        res_vld_q <= 1'b1;
                        state_q   <= HOLD;
                    end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                        res_q     <= QNAN;
                        res_ovf_q <= 1'b0;
                        res_tag_q <= pend_tag_q;
                        res_tmo_q <= 1'b1;
                        res_vld_q <= 1'b1;
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_res_rdy) begin
                        res_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_alu_a       = alu_a_q;
    assign o_alu_b       = alu_b_q;
    assign o_alu_op      = alu_op_q;
    assign o_alu_vld     = alu_vld_q;
    assign o_res_vld     = res_vld_q;
    assign o_res         = res_q;
    assign o_res_ovf     = res_ovf_q;
    assign o_res_tag     = res_tag_q;
    assign o_res_timeout = res_tmo_q;

endmodule
